priv_perf_counters: RTL and testbench
=====================================

# priv_perf_counters

Machine-mode performance-counter unit inside the privilege block. Consumes the retire, miss, stall and flush indications the pipeline and caches drive toward the privilege block. Maintains the 64-bit mcycle, minstret and mhpmcounter3–6 counters plus mcountinhibit. Serves them through the privilege block's CSR read/modify/write path.

## Interface
Parameters:
- NUM_HPM, 4, number of mhpmcounters (3..3+NUM_HPM-1); legal range 0–4
- CNT_W, 64, counter width; low half is CSR bits [31:0], high half is bits [CNT_W-1:32]

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- wb_enable  in  1  writeback stage advancing
- instr  in  1  valid instruction in writeback
- icache_miss  in  1  I-cache miss level (held for miss duration)
- dcache_miss  in  1  D-cache miss level
- ex_mem_stall  in  1  EX/MEM stalled this cycle
- pipe_clear  in  1  pipeline flush this cycle
- csr_addr  in  12  CSR address
- swap, set, clr  in  1 each  CSR operation (one-hot or none)
- valid_write  in  1  CSR write permitted this cycle
- wdata  in  32  CSR operand
- rdata  out  32  CSR read data
- csr_hit  out  1  csr_addr maps to a register in this block

## Operation
- Address map: mcycle 0xB00/0xB80, minstret 0xB02/0xB82, mhpmcounter3–6 0xB03–0xB06/0xB83–0xB86, mcountinhibit 0x320. User shadows are read-only: cycle 0xC00/0xC80, instret 0xC02/0xC82, hpmcounter3–6 0xC03–0xC06/0xC83–0xC86. Unimplemented hpm addresses below 3+NUM_HPM: csr_hit=1, read 0. Others: csr_hit=0, rdata=0.
- Increment sources, each gated by its mcountinhibit bit:
  - mcycle: every cycle; bit 0.
  - minstret: wb_enable & instr; bit 2.
  - hpm3: rising edge of icache_miss.
  - hpm4: rising edge of dcache_miss.
  - hpm5: cycles with ex_mem_stall.
  - hpm6: cycles with pipe_clear.
  - hpmN uses inhibit bit N.
- Edge detect uses registered copies of icache_miss/dcache_miss, reset 0. A miss held N cycles counts once.
- mcountinhibit: bits 0, 2, 3..2+NUM_HPM are writable; all other bits read 0.
- Write enable = valid_write & (swap|set|clr) & address in 0xB00–0xB86 range or 0x320.
- New value: swap → wdata; set → old|wdata; clr → old&~wdata.
- Writes to 0xCxx are ignored.
- A write to the low half replaces bits [31:0]. The high half is unchanged and no carry propagates that cycle. A write to the high half replaces the upper bits; the low half still increments normally without carry-in from this cycle.
- Write and increment on the same counter-half in the same cycle: the written value wins; that counter does not increment.
- Counters wrap to 0 at 2^CNT_W with no flag.
- Reset: all counters, mcountinhibit, edge registers = 0. rdata/csr_hit are combinational and follow csr_addr after reset.

## Timing
- rdata is combinational from current register state: same-cycle read returns the pre-write value.
- Write effect visible on rdata the cycle after the edge.
- Increment visible one cycle after the qualifying input cycle.
- Edge-detected events: a rising edge in cycle t is counted at the edge ending t.
- Inhibit bit written at edge t gates increments from cycle t+1.
- nRST low mid-operation clears all state at the next edge regardless of simultaneous write or increment.

## Configuration
- PERF_HPM_EN defined: mhpmcounter3..3+NUM_HPM-1 and their inhibit bits are implemented as above.
- PERF_HPM_EN undefined: no hpm storage or edge registers. hpm addresses keep csr_hit=1, read 0, ignore writes. mcountinhibit bits 3+ read 0. mcycle/minstret are unaffected.

## Structure
- CSR address constants (0xB00, 0xB80, 0xC00, 0xC80, 0x320 and offsets) and the mcountinhibit_t packed struct belong in priv_isa_types_pkg.
- One sub-module, perf_counter64: one CNT_W counter with inc, lo_we, hi_we, wdata. Instantiated 2+NUM_HPM times. Top level holds decode, RMW and edge detect.

## Test plan
- Reset, idle 10 cycles → read 0xB00 = 10; 0xB80 = 0; 0xC00 equals 0xB00.
- swap 0xB00 wdata 0xFFFFFFFF, hold 2 cycles → low reads 0x00000000 then 0x00000001 and high 0x00000001 (second cycle carries).
- wb_enable&instr 5 cycles, with wb_enable only in 3 further cycles → 0xB02 = 5; write 0xB02 in the same cycle as a retire → written value, no +1.
- icache_miss high 4 cycles, low 1, high 2 → 0xB03 = 2; ex_mem_stall 7 cycles → 0xB05 = 7; pipe_clear 3 pulses → 0xB06 = 3.
- set 0x320 wdata 0x5 → mcycle and minstret freeze, read 0x320 = 0x5; write 0x2 alone → reads 0x0; swap 0xC00 → no change.
- Build without PERF_HPM_EN → 0xB03 reads 0 with csr_hit=1 after icache_miss activity; 0x320 write 0x7F reads 0x5.

Source files
------------

// File: rtl/priv_isa_types_pkg.sv
// rtl/priv_isa_types_pkg.sv - CSR address constants and mcountinhibit layout for the privilege block
package priv_isa_types_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_MCNT_LAST     = 12'hB86;

    localparam logic [6:0] CSR_OFF_CYCLE   = 7'd0;
    localparam logic [6:0] CSR_OFF_INSTRET = 7'd2;
    localparam logic [6:0] CSR_OFF_HPM3    = 7'd3;

    typedef struct packed {
        logic [28:0] hpm;
        logic        ir;
        logic        tm;
        logic        cy;
    } mcountinhibit_t;

endpackage

// File: rtl/priv_perf_counters_if.sv
// rtl/priv_perf_counters_if.sv - pipeline event inputs and CSR access path of the perf-counter unit
interface priv_perf_counters_if;
    logic        wb_enable;
    logic        instr;
    logic        icache_miss;
    logic        dcache_miss;
    logic        ex_mem_stall;
    logic        pipe_clear;
    logic [11:0] csr_addr;
    logic        swap;
    logic        set;
    logic        clr;
    logic        valid_write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        csr_hit;

    modport master (
        output wb_enable, instr, icache_miss, dcache_miss, ex_mem_stall, pipe_clear,
        output csr_addr, swap, set, clr, valid_write, wdata,
        input  rdata, csr_hit
    );

    modport slave (
        input  wb_enable, instr, icache_miss, dcache_miss, ex_mem_stall, pipe_clear,
        input  csr_addr, swap, set, clr, valid_write, wdata,
        output rdata, csr_hit
    );
endinterface

// File: rtl/priv_perf_counters_counter.sv
// rtl/priv_perf_counters_counter.sv - one CNT_W event counter with independent low/high half writes
module perf_counter64 #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             lo_we_i,
    input  logic             hi_we_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int HI_W = CNT_W - 32;

    logic [31:0]     lo_q, lo_d;
    logic [HI_W-1:0] hi_q, hi_d;
    logic            carry;

    assign carry = inc_i & (&lo_q);

    // A write to either half suppresses this cycle's carry into the high half.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (lo_we_i)
            lo_d = wdata_i;
        else if (inc_i)
            lo_d = lo_q + 32'd1;
        if (hi_we_i)
            hi_d = wdata_i[HI_W-1:0];
        else if (!lo_we_i && carry)
            hi_d = hi_q + {{(HI_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign cnt_o = {hi_q, lo_q};
endmodule

// File: rtl/priv_perf_counters.sv
// rtl/priv_perf_counters.sv - machine-mode cycle/instret/hpm counters with CSR decode and RMW
// Macro PERF_HPM_EN enables mhpmcounter storage, miss edge detection and hpm inhibit bits.
module priv_perf_counters
    import priv_isa_types_pkg::*;
#(
    parameter int NUM_HPM = 4,
    parameter int CNT_W   = 64
) (
    input  logic                 CLK,
    input  logic                 nRST,
    priv_perf_counters_if.slave  bus
);
`ifdef PERF_HPM_EN
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
`else
    localparam logic [31:0] INH_MASK = 32'h5;
`endif

    logic [11:0]      addr;
    logic [6:0]       idx;
    logic             page_ok, cnt_hit, we_any, wr_cnt, inh_we;
    logic [6:0]       lo_we, hi_we;
    logic [31:0]      new_val;
    logic [63:0]      sel_cnt;
    logic [CNT_W-1:0] cnt_val [0:6];
    mcountinhibit_t   inh_q, inh_d;

    assign addr    = bus.csr_addr;
    assign idx     = addr[6:0];
    assign page_ok = (addr[11:8] == CSR_MCYCLE[11:8]) || (addr[11:8] == CSR_CYCLE[11:8]);
    assign cnt_hit = page_ok && ((idx == CSR_OFF_CYCLE) || (idx == CSR_OFF_INSTRET) ||
                     ((idx >= CSR_OFF_HPM3) && (int'(idx) < 3 + NUM_HPM)));

    always_comb begin
        bus.rdata   = '0;
        bus.csr_hit = 1'b0;
        sel_cnt     = '0;
        if (addr == CSR_MCOUNTINHIBIT) begin
            bus.csr_hit = 1'b1;
            bus.rdata   = inh_q;
        end else if (cnt_hit) begin
            bus.csr_hit = 1'b1;
            sel_cnt     = 64'(cnt_val[idx[2:0]]);
            bus.rdata   = addr[7] ? sel_cnt[63:32] : sel_cnt[31:0];
        end
    end

    // RMW operand is the currently addressed half, i.e. the pre-write read data.
    always_comb begin
        new_val = bus.rdata;
        if (bus.swap)
            new_val = bus.wdata;
        else if (bus.set)
            new_val = bus.rdata | bus.wdata;
        else if (bus.clr)
            new_val = bus.rdata & ~bus.wdata;
    end

    assign we_any = bus.valid_write & (bus.swap | bus.set | bus.clr);
    assign wr_cnt = we_any && (addr >= CSR_MCYCLE) && (addr <= CSR_MCNT_LAST) && (idx < 7'd7);
    assign inh_we = we_any && (addr == CSR_MCOUNTINHIBIT);
    assign lo_we  = (wr_cnt && !addr[7]) ? (7'b1 << idx[2:0]) : 7'b0;
    assign hi_we  = (wr_cnt &&  addr[7]) ? (7'b1 << idx[2:0]) : 7'b0;
    assign inh_d  = inh_we ? mcountinhibit_t'(new_val & INH_MASK) : inh_q;

    always_ff @(posedge CLK) begin
        if (!nRST)
            inh_q <= '0;
        else
            inh_q <= inh_d;
    end

    perf_counter64 #(.CNT_W(CNT_W)) u_mcycle (
        .clk_i(CLK), .rst_ni(nRST), .inc_i(~inh_q.cy),
        .lo_we_i(lo_we[0]), .hi_we_i(hi_we[0]), .wdata_i(new_val), .cnt_o(cnt_val[0])
    );

    perf_counter64 #(.CNT_W(CNT_W)) u_minstret (
        .clk_i(CLK), .rst_ni(nRST), .inc_i(bus.wb_enable & bus.instr & ~inh_q.ir),
        .lo_we_i(lo_we[2]), .hi_we_i(hi_we[2]), .wdata_i(new_val), .cnt_o(cnt_val[2])
    );

    assign cnt_val[1] = '0;

`ifdef PERF_HPM_EN
    logic       ic_q, dc_q;
    logic [3:0] ev;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ic_q <= 1'b0;
            dc_q <= 1'b0;
        end else begin
            ic_q <= bus.icache_miss;
            dc_q <= bus.dcache_miss;
        end
    end

    // Misses are levels held for the whole miss; count only their rising edge.
    assign ev = {bus.pipe_clear, bus.ex_mem_stall,
                 bus.dcache_miss & ~dc_q, bus.icache_miss & ~ic_q};

    for (genvar k = 0; k < 4; k++) begin : g_hpm
        if (k < NUM_HPM) begin : g_on
            perf_counter64 #(.CNT_W(CNT_W)) u_hpm (
                .clk_i(CLK), .rst_ni(nRST), .inc_i(ev[k] & ~inh_q.hpm[k]),
                .lo_we_i(lo_we[3+k]), .hi_we_i(hi_we[3+k]), .wdata_i(new_val),
                .cnt_o(cnt_val[3+k])
            );
        end else begin : g_off
            assign cnt_val[3+k] = '0;
        end
    end
`else
    for (genvar k = 0; k < 4; k++) begin : g_hpm
        assign cnt_val[3+k] = '0;
    end
`endif
endmodule

// File: tb/tb_priv_perf_counters.sv
// tb/tb_priv_perf_counters.sv - directed-vector bench for priv_perf_counters
module tb_priv_perf_counters;
    logic clk;
    logic nrst;
    int   n_vec;
    int   n_miss;

    priv_perf_counters_if bus ();

    priv_perf_counters #(.NUM_HPM(4), .CNT_W(64)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_addr = a;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic hit(input string tag, input logic [11:0] a, input logic exp);
        bus.csr_addr = a;
        #1;
        check(tag, {31'b0, bus.csr_hit}, {31'b0, exp});
    endtask

    // op = {swap, set, clr}; one clock with the request held, then released
    task automatic wr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d,
                      input logic vw);
        bus.csr_addr    = a;
        bus.wdata       = d;
        bus.valid_write = vw;
        {bus.swap, bus.set, bus.clr} = op;
        cyc(1);
        {bus.swap, bus.set, bus.clr} = 3'b000;
        bus.valid_write = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        nrst = 1'b0;
        bus.wb_enable = 0; bus.instr = 0; bus.icache_miss = 0; bus.dcache_miss = 0;
        bus.ex_mem_stall = 0; bus.pipe_clear = 0; bus.csr_addr = '0;
        bus.swap = 0; bus.set = 0; bus.clr = 0; bus.valid_write = 0; bus.wdata = '0;

        cyc(3);
        rd("rst_mcycle", 12'hB00, 32'h0);
        rd("rst_inhibit", 12'h320, 32'h0);
        hit("rst_hit_320", 12'h320, 1'b1);

        nrst = 1'b1;
        cyc(10);
        rd("idle_mcycle", 12'hB00, 32'd10);
        rd("idle_mcycleh", 12'hB80, 32'd0);
        rd("idle_cycle_shadow", 12'hC00, 32'd10);
        hit("hit_b01", 12'hB01, 1'b0);
        hit("hit_c80", 12'hC80, 1'b1);
        hit("hit_b07", 12'hB07, 1'b0);
        rd("rd_unmapped", 12'h123, 32'h0);

        // same-cycle read returns pre-write value
        bus.csr_addr = 12'hB00; bus.wdata = 32'hFFFF_FFFF; bus.valid_write = 1; bus.swap = 1;
        #1;
        check("pre_write_read", bus.rdata, 32'd10);
        cyc(1);
        bus.swap = 0; bus.valid_write = 0;
        rd("lo_written", 12'hB00, 32'hFFFF_FFFF);
        rd("hi_before_carry", 12'hB80, 32'h0);
        cyc(1);
        rd("lo_wrapped", 12'hB00, 32'h0);
        rd("hi_carried", 12'hB80, 32'h1);
        cyc(1);
        rd("lo_after_carry", 12'hB00, 32'h1);
        wr(3'b100, 12'hB80, 32'h0, 1'b1);
        rd("hi_write", 12'hB80, 32'h0);
        rd("lo_runs_during_hi_write", 12'hB00, 32'h2);
        wr(3'b100, 12'hB80, 32'hFFFF_FFFF, 1'b1);
        wr(3'b100, 12'hB00, 32'hFFFF_FFFF, 1'b1);
        rd("hi_max", 12'hB80, 32'hFFFF_FFFF);
        rd("lo_max", 12'hB00, 32'hFFFF_FFFF);
        cyc(1);
        rd("wrap_lo", 12'hB00, 32'h0);
        rd("wrap_hi", 12'hB80, 32'h0);

        bus.wb_enable = 1; bus.instr = 1;
        cyc(5);
        bus.instr = 0;
        cyc(3);
        bus.wb_enable = 0;
        rd("minstret_5", 12'hB02, 32'd5);
        bus.wb_enable = 1; bus.instr = 1;
        wr(3'b100, 12'hB02, 32'h100, 1'b1);
        bus.wb_enable = 0; bus.instr = 0;
        rd("write_beats_retire", 12'hB02, 32'h100);
        rd("instret_shadow", 12'hC02, 32'h100);
        rd("instreth_shadow", 12'hC82, 32'h0);
        wr(3'b010, 12'hB02, 32'h3, 1'b1);
        rd("set_op", 12'hB02, 32'h103);
        wr(3'b001, 12'hB02, 32'h101, 1'b1);
        rd("clr_op", 12'hB02, 32'h2);
        wr(3'b100, 12'hB02, 32'hFFFF, 1'b0);
        rd("no_valid_write", 12'hB02, 32'h2);
        wr(3'b100, 12'hC02, 32'hAA, 1'b1);
        rd("shadow_write_ignored", 12'hB02, 32'h2);

        bus.icache_miss = 1; cyc(4);
        bus.icache_miss = 0; cyc(1);
        bus.icache_miss = 1; cyc(2);
        bus.icache_miss = 0;
        bus.dcache_miss = 1; cyc(3);
        bus.dcache_miss = 0;
        bus.ex_mem_stall = 1; cyc(7);
        bus.ex_mem_stall = 0;
        for (int i = 0; i < 3; i++) begin
            bus.pipe_clear = 1; cyc(1);
            bus.pipe_clear = 0; cyc(1);
        end
`ifdef PERF_HPM_EN
        rd("hpm3_icache_edges", 12'hB03, 32'd2);
        rd("hpm4_dcache_edges", 12'hB04, 32'd1);
        rd("hpm5_stalls", 12'hB05, 32'd7);
        rd("hpm6_flushes", 12'hB06, 32'd3);
        rd("hpm3_shadow", 12'hC03, 32'd2);
`else
        rd("hpm3_absent", 12'hB03, 32'd0);
        hit("hpm3_absent_hit", 12'hB03, 1'b1);
        rd("hpm6_absent", 12'hB06, 32'd0);
        wr(3'b100, 12'hB05, 32'h77, 1'b1);
        rd("hpm5_write_ignored", 12'hB05, 32'd0);
`endif

        wr(3'b010, 12'h320, 32'h5, 1'b1);
        rd("inhibit_set", 12'h320, 32'h5);
        wr(3'b100, 12'hB00, 32'h55, 1'b1);
        rd("inhibited_write", 12'hB00, 32'h55);
        cyc(3);
        rd("mcycle_frozen", 12'hB00, 32'h55);
        wr(3'b100, 12'hC00, 32'h1234, 1'b1);
        rd("cycle_shadow_ro", 12'hB00, 32'h55);
        bus.wb_enable = 1; bus.instr = 1;
        cyc(2);
        bus.wb_enable = 0; bus.instr = 0;
        rd("minstret_frozen", 12'hB02, 32'h2);
        wr(3'b100, 12'h320, 32'h7F, 1'b1);
`ifdef PERF_HPM_EN
        rd("inhibit_mask", 12'h320, 32'h7D);
`else
        rd("inhibit_mask", 12'h320, 32'h5);
`endif
        wr(3'b100, 12'h320, 32'h2, 1'b1);
        rd("inhibit_bit1_ro", 12'h320, 32'h0);
        rd("uninhibit_edge", 12'hB00, 32'h55);
        cyc(1);
        rd("uninhibit_next", 12'hB00, 32'h56);

        nrst = 1'b0;
        bus.wb_enable = 1; bus.instr = 1;
        wr(3'b100, 12'h320, 32'h5, 1'b1);
        bus.wb_enable = 0; bus.instr = 0;
        rd("midrst_mcycle", 12'hB00, 32'h0);
        rd("midrst_minstret", 12'hB02, 32'h0);
        rd("midrst_inhibit", 12'h320, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
